rotate_scale_addr_gen: RTL and testbench
========================================

ROTATE_SCALE_ADDR_GEN -- requirements
Module: rotate_scale_addr_gen

Interface
REQ-001 SHALL have parameter DISP_W, default 800, display columns.
REQ-002 SHALL have parameter DISP_H, default 480, display rows.
REQ-003 SHALL have parameter ADDR_W, default 19, pixel address width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, output FIFO entries (power of 2, >=8).
REQ-005 SHALL have parameter TRIG_W, default 9, signed sin/cos width, Q1.(TRIG_W-2), so 1.0 = 128 at default.
REQ-006 SHALL have port CLK  input  1  sole clock, rising edge.
REQ-007 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port iMODE  input  2  00 identity, 01 rotate, 10 rotate+scale, 11 scale only.
REQ-009 SHALL have port iSIN  input  TRIG_W  signed sine of rotation angle.
REQ-010 SHALL have port iCOS  input  TRIG_W  signed cosine of rotation angle.
REQ-011 SHALL have port iSCALE  input  8  unsigned inverse zoom, Q2.6 (64 = 1.0).
REQ-012 SHALL have port iFLIP_V  input  1  1 = vertically flipped address.
REQ-013 SHALL have port iREAD  input  1  pop one FIFO entry.
REQ-014 SHALL have port oADDRESS  output  ADDR_W+1  FIFO head {valid, address}.
REQ-015 SHALL have port oREADY_N  output  1  FIFO empty.
REQ-016 SHALL have port oLEVEL  output  log2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-017 SHALL have port oFRAME_SYNC  output  1  one-cycle pulse when last pixel of a frame is written to FIFO.

Function
REQ-018 Column/row counter SHALL scan raster order, column 0..DISP_W-1, then row 0..DISP_H-1, wrapping to (0,0) after (DISP_W-1, DISP_H-1).
REQ-019 Counter SHALL advance only when credit available: FIFO level + in-flight pipeline entries < FIFO_DEPTH.
REQ-020 Pipeline SHALL be 4 stages (centre, multiply, shift/scale+bounds, address); counter advance to FIFO write latency is exactly 4 cycles; each issued pixel SHALL produce exactly one FIFO write, no drops, no overflow.
REQ-021 iMODE, iSIN, iCOS, iSCALE, iFLIP_V SHALL be captured into shadow registers only when the counter issues pixel (0,0); mid-frame changes SHALL have no effect until next frame.
REQ-022 With dx = col - DISP_W/2, dy = row - DISP_H/2 (signed, 16+ bits), rotate: x' = (dx*cos - dy*sin) >>> (TRIG_W-2), y' = (dx*sin + dy*cos) >>> (TRIG_W-2); identity/scale-only use cos = 1.0, sin = 0.
REQ-023 Scale modes SHALL apply x'' = (x'*iSCALE) >>> 6, likewise y''; non-scale modes use x'' = x', y'' = y'.
REQ-024 All shifts SHALL be arithmetic (floor toward minus infinity); intermediate widths SHALL not overflow for any legal input.
REQ-025 x = x'' + DISP_W/2, y = y'' + DISP_H/2; valid = 0 <= x < DISP_W and 0 <= y < DISP_H.
REQ-026 Address SHALL be (DISP_H-1-y)*DISP_W + x when flip = 1, y*DISP_W + x when flip = 0; when valid = 0 address field SHALL be 0.
REQ-027 FIFO SHALL be show-ahead: oADDRESS presents head while oREADY_N = 0; iREAD pops on the same edge.
REQ-028 iREAD while empty SHALL be ignored (no pointer/level change).
REQ-029 Simultaneous write and read SHALL keep oLEVEL unchanged; simultaneous write and read when empty SHALL not bypass (entry appears next cycle).
REQ-030 oFRAME_SYNC SHALL pulse high for exactly the cycle the entry for pixel (DISP_W-1, DISP_H-1) is written.

Reset
REQ-031 While RESET = 1: counter = (0,0), pipeline valids cleared, FIFO emptied, oREADY_N = 1, oLEVEL = 0, oFRAME_SYNC = 0, oADDRESS = 0, shadow registers = identity, scale 64, flip 0.
REQ-032 Reset asserted mid-frame SHALL discard in-flight and buffered entries; after release first issued pixel SHALL be (0,0) with fresh shadow capture.

Verification
REQ-033 Identity, flip=0, iREAD held 1 -> addresses 0,1,2,... all valid; after 384000 entries sequence restarts at 0 with one oFRAME_SYNC.
REQ-034 Identity, flip=1 -> first address 383200 (=479*800), pixel (799,479) gives 799.
REQ-035 Rotate, sin=128, cos=0 (90 deg), flip=0 -> pixel (0,0) (dx=-400, dy=-240): x=640, y=-160, valid=0; pixel (400,240) -> address 192400, valid=1.
REQ-036 Rotate+scale, sin=0, cos=128, iSCALE=32 -> pixel (0,0) maps x=200, y=120, address 96200; pixel (799,479) maps x=599, y=359.
REQ-037 iREAD held 0 -> oLEVEL saturates at FIFO_DEPTH, counter stalls, no entry lost; resume reads -> sequence continues contiguous; iREAD while empty -> no change.
REQ-038 Change iMODE mid-frame -> current frame output unchanged; new mode effective from next (0,0); RESET pulse mid-frame -> oREADY_N = 1 immediately, restart at (0,0).

Source files
------------

// File: rtl/rotate_scale_addr_gen_if.sv
// rotate_scale_addr_gen_if: frame configuration inputs and show-ahead FIFO port of the address generator
interface rotate_scale_addr_gen_if #(
  parameter int ADDR_W = 19,
  parameter int FIFO_DEPTH = 16,
  parameter int TRIG_W = 9
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  logic [1:0] iMODE;
  logic signed [TRIG_W-1:0] iSIN;
  logic signed [TRIG_W-1:0] iCOS;
  logic [7:0] iSCALE;
  logic iFLIP_V;
  logic iREAD;
  logic [ADDR_W:0] oADDRESS;
  logic oREADY_N;
  logic [LW-1:0] oLEVEL;
  logic oFRAME_SYNC;
  modport master (
    input iMODE, iSIN, iCOS, iSCALE, iFLIP_V, iREAD,
    output oADDRESS, oREADY_N, oLEVEL, oFRAME_SYNC
  );
  modport slave (
    output iMODE, iSIN, iCOS, iSCALE, iFLIP_V, iREAD,
    input oADDRESS, oREADY_N, oLEVEL, oFRAME_SYNC
  );
endinterface

// File: rtl/rotate_scale_addr_gen.sv
// rotate_scale_addr_gen: raster scan through a rotate/scale inverse mapping, buffered in a show-ahead FIFO
module rotate_scale_addr_gen #(
  parameter int DISP_W = 800,
  parameter int DISP_H = 480,
  parameter int ADDR_W = 19,
  parameter int FIFO_DEPTH = 16,
  parameter int TRIG_W = 9
) (
  input logic CLK,
  input logic RESET,
  rotate_scale_addr_gen_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int FB = TRIG_W - 2;
  localparam int PW = TRIG_W + 17;
  localparam int SW = PW + 9;
  localparam logic signed [TRIG_W-1:0] ONE = TRIG_W'(1 << FB);

  logic [15:0] col_q, col_d, row_q, row_d;
  logic [1:0] mode_q, mode_d;
  logic signed [TRIG_W-1:0] sin_q, sin_d, cos_q, cos_d;
  logic [7:0] scale_q, scale_d;
  logic flip_q, flip_d;
  logic s1_v_q, s1_v_d, s1_scl_q, s1_scl_d, s1_flip_q, s1_flip_d, s1_last_q, s1_last_d;
  logic signed [15:0] s1_dx_q, s1_dx_d, s1_dy_q, s1_dy_d;
  logic signed [TRIG_W-1:0] s1_sin_q, s1_sin_d, s1_cos_q, s1_cos_d;
  logic [7:0] s1_scale_q, s1_scale_d;
  logic s2_v_q, s2_v_d, s2_scl_q, s2_scl_d, s2_flip_q, s2_flip_d, s2_last_q, s2_last_d;
  logic signed [PW-1:0] s2_xr_q, s2_xr_d, s2_yr_q, s2_yr_d;
  logic [7:0] s2_scale_q, s2_scale_d;
  logic s3_v_q, s3_v_d, s3_in_q, s3_in_d, s3_flip_q, s3_flip_d, s3_last_q, s3_last_d;
  logic [15:0] s3_x_q, s3_x_d, s3_y_q, s3_y_d;
  logic s4_v_q, s4_v_d, s4_last_q, s4_last_d;
  logic [ADDR_W:0] s4_addr_q, s4_addr_d;
  logic [LW-1:0] wp_q, wp_d, rp_q, rp_d, level;
  logic fs_q, fs_d;
  logic [ADDR_W:0] mem [FIFO_DEPTH];
  logic origin, adv, empty, pop;
  logic [2:0] inflight;
  logic signed [PW-1:0] xs, ys;
  logic signed [SW-1:0] xm, ym, xf, yf;
  logic [15:0] row_sel;
  logic [ADDR_W-1:0] lin;

  always_comb begin
    origin = col_q == '0 && row_q == '0;
    level = wp_q - rp_q;
    empty = wp_q == rp_q;
    pop = bus.iREAD && !empty;
    inflight = 3'(s1_v_q) + 3'(s2_v_q) + 3'(s3_v_q) + 3'(s4_v_q);
    // in-flight pixels already own a FIFO slot, so the FIFO can never overflow
    adv = int'(level) + int'(inflight) < FIFO_DEPTH;
    col_d = adv ? (col_q == 16'(DISP_W - 1) ? '0 : col_q + 16'd1) : col_q;
    row_d = adv && col_q == 16'(DISP_W - 1) ? (row_q == 16'(DISP_H - 1) ? '0 : row_q + 16'd1) : row_q;
    mode_d = adv && origin ? bus.iMODE : mode_q;
    sin_d = adv && origin ? bus.iSIN : sin_q;
    cos_d = adv && origin ? bus.iCOS : cos_q;
    scale_d = adv && origin ? bus.iSCALE : scale_q;
    flip_d = adv && origin ? bus.iFLIP_V : flip_q;
    // each pixel carries its own frame settings so a new frame never leaks into the previous one
    s1_v_d = adv;
    s1_dx_d = $signed(col_q) - 16'(DISP_W / 2);
    s1_dy_d = $signed(row_q) - 16'(DISP_H / 2);
    s1_cos_d = mode_d[0] ^ mode_d[1] ? cos_d : ONE;
    s1_sin_d = mode_d[0] ^ mode_d[1] ? sin_d : '0;
    s1_scl_d = mode_d[1];
    s1_scale_d = scale_d;
    s1_flip_d = flip_d;
    s1_last_d = col_q == 16'(DISP_W - 1) && row_q == 16'(DISP_H - 1);
    s2_v_d = s1_v_q;
    s2_xr_d = PW'(s1_dx_q) * PW'(s1_cos_q) - PW'(s1_dy_q) * PW'(s1_sin_q);
    s2_yr_d = PW'(s1_dx_q) * PW'(s1_sin_q) + PW'(s1_dy_q) * PW'(s1_cos_q);
    s2_scl_d = s1_scl_q;
    s2_scale_d = s1_scale_q;
    s2_flip_d = s1_flip_q;
    s2_last_d = s1_last_q;
    xs = s2_xr_q >>> FB;
    ys = s2_yr_q >>> FB;
    xm = SW'(xs) * SW'($signed({1'b0, s2_scale_q}));
    ym = SW'(ys) * SW'($signed({1'b0, s2_scale_q}));
    xf = (s2_scl_q ? xm >>> 6 : SW'(xs)) + SW'(DISP_W / 2);
    yf = (s2_scl_q ? ym >>> 6 : SW'(ys)) + SW'(DISP_H / 2);
    s3_v_d = s2_v_q;
    s3_in_d = !xf[SW-1] && xf < SW'(DISP_W) && !yf[SW-1] && yf < SW'(DISP_H);
    s3_x_d = xf[15:0];
    s3_y_d = yf[15:0];
    s3_flip_d = s2_flip_q;
    s3_last_d = s2_last_q;
    row_sel = s3_flip_q ? 16'(DISP_H - 1) - s3_y_q : s3_y_q;
    lin = ADDR_W'(32'(row_sel) * 32'(DISP_W) + 32'(s3_x_q));
    s4_v_d = s3_v_q;
    s4_addr_d = s3_in_q ? {1'b1, lin} : '0;
    s4_last_d = s3_last_q;
    wp_d = wp_q + LW'(s4_v_q);
    rp_d = rp_q + LW'(pop);
    fs_d = s4_v_q && s4_last_q;
  end

  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      col_q <= '0; row_q <= '0;
      mode_q <= '0; sin_q <= '0; cos_q <= ONE; scale_q <= 8'd64; flip_q <= 1'b0;
      s1_v_q <= 1'b0; s1_dx_q <= '0; s1_dy_q <= '0; s1_sin_q <= '0; s1_cos_q <= '0;
      s1_scl_q <= 1'b0; s1_scale_q <= '0; s1_flip_q <= 1'b0; s1_last_q <= 1'b0;
      s2_v_q <= 1'b0; s2_xr_q <= '0; s2_yr_q <= '0; s2_scl_q <= 1'b0; s2_scale_q <= '0;
      s2_flip_q <= 1'b0; s2_last_q <= 1'b0;
      s3_v_q <= 1'b0; s3_in_q <= 1'b0; s3_x_q <= '0; s3_y_q <= '0; s3_flip_q <= 1'b0; s3_last_q <= 1'b0;
      s4_v_q <= 1'b0; s4_addr_q <= '0; s4_last_q <= 1'b0;
      wp_q <= '0; rp_q <= '0; fs_q <= 1'b0;
    end else begin
      col_q <= col_d; row_q <= row_d;
      mode_q <= mode_d; sin_q <= sin_d; cos_q <= cos_d; scale_q <= scale_d; flip_q <= flip_d;
      s1_v_q <= s1_v_d; s1_dx_q <= s1_dx_d; s1_dy_q <= s1_dy_d; s1_sin_q <= s1_sin_d; s1_cos_q <= s1_cos_d;
      s1_scl_q <= s1_scl_d; s1_scale_q <= s1_scale_d; s1_flip_q <= s1_flip_d; s1_last_q <= s1_last_d;
      s2_v_q <= s2_v_d; s2_xr_q <= s2_xr_d; s2_yr_q <= s2_yr_d; s2_scl_q <= s2_scl_d; s2_scale_q <= s2_scale_d;
      s2_flip_q <= s2_flip_d; s2_last_q <= s2_last_d;
      s3_v_q <= s3_v_d; s3_in_q <= s3_in_d; s3_x_q <= s3_x_d; s3_y_q <= s3_y_d; s3_flip_q <= s3_flip_d;
      s3_last_q <= s3_last_d;
      s4_v_q <= s4_v_d; s4_addr_q <= s4_addr_d; s4_last_q <= s4_last_d;
      wp_q <= wp_d; rp_q <= rp_d; fs_q <= fs_d;
    end

  always_ff @(posedge CLK)
    if (s4_v_q) mem[wp_q[AW-1:0]] <= s4_addr_q;

  assign bus.oADDRESS = empty ? '0 : mem[rp_q[AW-1:0]];
  assign bus.oREADY_N = empty;
  assign bus.oLEVEL = level;
  assign bus.oFRAME_SYNC = fs_q;
endmodule

// File: tb/tb_rotate_scale_addr_gen.sv
// tb_rotate_scale_addr_gen: directed frames checked every cycle against an arithmetic model of the mapping
`timescale 1ns/1ps
module tb_rotate_scale_addr_gen;
  localparam int W = 40, H = 24, N = W * H, AW = 10, DEPTH = 8, TW = 9;
  typedef struct {int m; int s; int c; int sc; int fl;} cfg_t;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  rotate_scale_addr_gen_if #(.ADDR_W(AW), .FIFO_DEPTH(DEPTH), .TRIG_W(TW)) bus ();
  rotate_scale_addr_gen #(.DISP_W(W), .DISP_H(H), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .TRIG_W(TW))
    dut (.CLK(clk), .RESET(rst), .bus(bus));

  cfg_t fcfg [8];
  int popped = 0, n_cmp = 0, n_bad = 0, timeouts = 0;
  logic done = 1'b0, stall_chk = 1'b0;

  function automatic cfg_t mk(int m, int s, int c, int sc, int fl);
    cfg_t r;
    r.m = m; r.s = s; r.c = c; r.sc = sc; r.fl = fl;
    return r;
  endfunction

  function automatic int fdiv(int a, int b);
    return (a < 0 && a % b != 0) ? a / b - 1 : a / b;
  endfunction

  function automatic int model(int col, int row, cfg_t c);
    int s, co, dx, dy, xp, yp, x, y;
    s = (c.m == 1 || c.m == 2) ? c.s : 0;
    co = (c.m == 1 || c.m == 2) ? c.c : 128;
    dx = col - W / 2;
    dy = row - H / 2;
    xp = fdiv(dx * co - dy * s, 128);
    yp = fdiv(dx * s + dy * co, 128);
    if (c.m >= 2) begin
      xp = fdiv(xp * c.sc, 64);
      yp = fdiv(yp * c.sc, 64);
    end
    x = xp + W / 2;
    y = yp + H / 2;
    if (x < 0 || x >= W || y < 0 || y >= H) return 0;
    return (1 << AW) + (c.fl != 0 ? (H - 1 - y) * W + x : y * W + x);
  endfunction

  task automatic chk(string nm, logic [31:0] act, int exp);
    n_cmp++;
    if (act !== 32'(exp)) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (entry %0d)", nm, act, exp, popped);
    end
  endtask

  initial begin : cmp
    int written, prev_w, cyc;
    bit seen;
    prev_w = 0; cyc = 0; seen = 0;
    chk("pin_id_first", model(0, 0, mk(0, 0, 0, 64, 0)), 1024);
    chk("pin_id_last", model(39, 23, mk(0, 0, 0, 64, 0)), 1983);
    chk("pin_flip_first", model(0, 0, mk(0, 0, 0, 64, 1)), 1944);
    chk("pin_flip_last", model(39, 23, mk(0, 0, 0, 64, 1)), 1063);
    chk("pin_rot90_corner", model(0, 0, mk(1, 128, 0, 64, 0)), 0);
    chk("pin_rot90_centre", model(20, 12, mk(1, 128, 0, 64, 0)), 1524);
    chk("pin_rs_first", model(0, 0, mk(2, 0, 128, 32, 0)), 1274);
    chk("pin_rs_last", model(39, 23, mk(2, 0, 128, 32, 0)), 1733);
    chk("pin_scale_floor", model(1, 1, mk(3, 0, 0, 32, 1)), 1714);
    chk("pin_rot45", model(25, 15, mk(1, 91, 91, 64, 0)), 1725);
    chk("pin_rot45_out", model(0, 0, mk(1, 91, 91, 64, 0)), 0);
    while (!done) begin
      @(negedge clk);
      if (rst) begin
        chk("rst_ready_n", 32'(bus.oREADY_N), 1);
        chk("rst_level", 32'(bus.oLEVEL), 0);
        chk("rst_address", 32'(bus.oADDRESS), 0);
        chk("rst_frame_sync", 32'(bus.oFRAME_SYNC), 0);
        popped = 0; prev_w = 0; cyc = 0; seen = 0;
      end else begin
        cyc++;
        written = popped + int'(bus.oLEVEL);
        chk("frame_sync", 32'(bus.oFRAME_SYNC), int'(written != prev_w && written % N == 0));
        prev_w = written;
        chk("level_max", 32'(bus.oLEVEL <= DEPTH), 1);
        if (stall_chk) chk("stall_level", 32'(bus.oLEVEL), DEPTH);
        if (!bus.oREADY_N) begin
          if (!seen) chk("first_latency", cyc, 6);
          seen = 1;
          chk("head", 32'(bus.oADDRESS), model((popped % N) % W, (popped % N) / W, fcfg[popped / N]));
          if (bus.iREAD) popped++;
        end
      end
    end
    chk("wait_timeouts", timeouts, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  task automatic apply(int slot, cfg_t c);
    bus.iMODE = 2'(c.m);
    bus.iSIN = TW'(c.s);
    bus.iCOS = TW'(c.c);
    bus.iSCALE = 8'(c.sc);
    bus.iFLIP_V = c.fl != 0;
    fcfg[slot] = c;
  endtask

  task automatic wait_w(int target, bit toggle);
    for (int k = 0; k < 6000; k++) begin
      @(posedge clk);
      #1;
      if (toggle) bus.iREAD = k % 3 != 0;
      if (popped + int'(bus.oLEVEL) >= target) return;
    end
    timeouts++;
  endtask

  initial begin : stim
    bus.iREAD = 1'b1;
    apply(0, mk(0, 0, 0, 64, 0));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    wait_w(N / 2, 0);
    apply(1, mk(1, 128, 0, 64, 0));
    wait_w(N / 2 + 40, 0);
    bus.iREAD = 1'b0;
    repeat (30) @(posedge clk);
    #1 stall_chk = 1'b1;
    @(posedge clk);
    #1 stall_chk = 1'b0;
    bus.iREAD = 1'b1;
    wait_w(N + N / 2, 0);
    apply(2, mk(2, 0, 128, 32, 0));
    wait_w(2 * N + N / 2, 1);
    bus.iREAD = 1'b1;
    apply(3, mk(3, 0, 0, 32, 1));
    wait_w(3 * N + N / 2, 0);
    apply(4, mk(1, 91, 91, 64, 0));
    wait_w(4 * N + N / 2, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    apply(0, mk(0, 0, 0, 64, 1));
    fcfg[1] = fcfg[0];
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wait_w(N + 100, 0);
    done = 1'b1;
  end
endmodule
